// File: rtl/alu_cmd_sequencer_pkg.sv
// Shared constants for the ALU command sequencer and the ALU itself:
// opcode encodings, sequencer FSM encodings and default widths.
package alu_cmd_sequencer_pkg;

  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned OP_W_DEF   = 3;

  localparam logic [OP_W_DEF-1:0] OP_PASS = 3'd0;
  localparam logic [OP_W_DEF-1:0] OP_MUL  = 3'd1;
  localparam logic [OP_W_DEF-1:0] OP_ADD  = 3'd2;
  localparam logic [OP_W_DEF-1:0] OP_SUB  = 3'd3;
  localparam logic [OP_W_DEF-1:0] OP_DIV  = 3'd4;
  localparam logic [OP_W_DEF-1:0] OP_MOD  = 3'd5;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_WB   = 2'd2;

  function automatic logic op_is_legal(input logic [OP_W_DEF-1:0] op);
    return op <= OP_MOD;
  endfunction

  function automatic logic op_divides(input logic [OP_W_DEF-1:0] op);
    return (op == OP_DIV) || (op == OP_MOD);
  endfunction

endpackage

// File: rtl/alu_cmd_sequencer_alu.sv
// Combinational unsigned ALU driven by alu_cmd_sequencer; results wrap to DATA_W.
// Division/modulo by zero and illegal opcodes yield zero (the sequencer discards them).
module alu_cmd_sequencer_alu
  import alu_cmd_sequencer_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned OP_W   = OP_W_DEF
) (
  input  logic [DATA_W-1:0] in_bus,
  input  logic [DATA_W-1:0] in_ac,
  input  logic [OP_W-1:0]   operation,
  output logic [DATA_W-1:0] data_out
);

  logic bus_zero;

  always_comb begin
    bus_zero = (in_bus == '0);
    data_out = '0;
    case (operation)
      OP_PASS: data_out = in_bus;
      OP_MUL:  data_out = in_ac * in_bus;
      OP_ADD:  data_out = in_ac + in_bus;
      OP_SUB:  data_out = in_ac - in_bus;
      OP_DIV:  data_out = bus_zero ? '0 : in_ac / in_bus;
      OP_MOD:  data_out = bus_zero ? '0 : in_ac % in_bus;
      default: data_out = '0;
    endcase
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Accepts one ALU command at a time, drives the ALU for a settle cycle and
// writes the result into the accumulator; flags illegal and divide-by-zero commands.
module alu_cmd_sequencer
  import alu_cmd_sequencer_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned OP_W   = OP_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [OP_W-1:0]   cmd_op,
  input  logic [DATA_W-1:0] cmd_operand,
  output logic [DATA_W-1:0] alu_in_bus,
  output logic [DATA_W-1:0] alu_in_ac,
  output logic [OP_W-1:0]   alu_operation,
  input  logic [DATA_W-1:0] alu_data_out,
  output logic [DATA_W-1:0] ac_out,
  output logic              busy,
  output logic              done,
  output logic              err
);

  logic [1:0] state;
  logic       cmd_fail;

  // Failure is judged on the registered command, which is what the ALU sees.
  always_comb begin
    cmd_fail = !op_is_legal(alu_operation) ||
               (op_divides(alu_operation) && (alu_in_bus == '0));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      ac_out        <= '0;
      alu_in_bus    <= '0;
      alu_operation <= OP_PASS;
      done          <= 1'b0;
      err           <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            alu_in_bus    <= cmd_operand;
            alu_operation <= cmd_op;
            state         <= S_EXEC;
          end
        end
        S_EXEC: state <= S_WB;
        S_WB: begin
          if (!cmd_fail) ac_out <= alu_data_out;
          done  <= 1'b1;
          err   <= cmd_fail;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready = (state == S_IDLE);
  assign busy      = !cmd_ready;
  assign alu_in_ac = ac_out;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Scoreboard bench for alu_cmd_sequencer wired to the real ALU.
module tb_alu_cmd_sequencer;

  localparam int unsigned DW = 16;
  localparam int unsigned OW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [OW-1:0] cmd_op = '0;
  logic [DW-1:0] cmd_operand = '0;
  logic [DW-1:0] alu_in_bus, alu_in_ac, alu_data_out, ac_out;
  logic [OW-1:0] alu_operation;
  logic          busy, done, err;

  typedef struct packed {
    logic [DW-1:0] ac;
    logic          err;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   chain_mode = 1'b0;
  int   chain_prev = -1;

  alu_cmd_sequencer #(.DATA_W(DW), .OP_W(OW)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_operand(cmd_operand), .alu_in_bus(alu_in_bus),
    .alu_in_ac(alu_in_ac), .alu_operation(alu_operation),
    .alu_data_out(alu_data_out), .ac_out(ac_out), .busy(busy),
    .done(done), .err(err)
  );

  alu_cmd_sequencer_alu #(.DATA_W(DW), .OP_W(OW)) alu (
    .in_bus(alu_in_bus), .in_ac(alu_in_ac), .operation(alu_operation),
    .data_out(alu_data_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse retires the oldest expectation.
  always @(negedge clk) begin
    if (done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'(done), 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("ac_out", 32'(ac_out), 32'(e.ac));
        chk("err", 32'(err), 32'(e.err));
        chk("alu_in_ac", 32'(alu_in_ac), 32'(ac_out));
      end
      if (chain_mode) begin
        if (chain_prev >= 0) chk("done_spacing", 32'(cyc - chain_prev), 32'd3);
        chain_prev = cyc;
      end
    end else if (err) begin
      chk("err_without_done", 32'(err), 32'd0);
    end
  end

  // Called at a negedge; returns at the negedge where cmd_ready is seen high.
  task automatic wait_ready();
    int n = 0;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) chk("cmd_ready_timeout", 32'(cmd_ready), 32'd1);
  endtask

  task automatic send(input logic [OW-1:0] op, input logic [DW-1:0] opnd,
                      input logic [DW-1:0] exp_ac, input logic exp_err);
    exp_t e;
    @(negedge clk);
    wait_ready();
    cmd_valid   = 1'b1;
    cmd_op      = op;
    cmd_operand = opnd;
    e.ac = exp_ac;
    e.err = exp_err;
    exp_q.push_back(e);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    // 1: reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ac", 32'(ac_out), 32'd0);
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_op", 32'(alu_operation), 32'd0);
    chk("rst_bus", 32'(alu_in_bus), 32'd0);
    rst = 1'b0;

    // 2: back-to-back chain, done every 3 cycles
    chain_mode = 1'b1;
    send(3'd0, 16'd7,  16'd7,      1'b0);
    send(3'd2, 16'd5,  16'd12,     1'b0);
    send(3'd1, 16'd3,  16'd36,     1'b0);
    send(3'd3, 16'd40, 16'hFFFC,   1'b0);
    drain();
    chain_mode = 1'b0;

    // 3: divide / modulo / divide by zero
    send(3'd0, 16'd17, 16'd17, 1'b0);
    send(3'd4, 16'd5,  16'd3,  1'b0);
    send(3'd0, 16'd17, 16'd17, 1'b0);
    send(3'd5, 16'd5,  16'd2,  1'b0);
    send(3'd4, 16'd0,  16'd2,  1'b1);
    send(3'd5, 16'd0,  16'd2,  1'b1);

    // 4: illegal opcodes, followed by a normal command
    send(3'd0, 16'd9, 16'd9,  1'b0);
    send(3'd6, 16'd4, 16'd9,  1'b1);
    send(3'd2, 16'd1, 16'd10, 1'b0);
    send(3'd7, 16'd0, 16'd10, 1'b1);

    // wrap boundaries
    send(3'd0, 16'd0,     16'd0,    1'b0);
    send(3'd3, 16'd1,     16'hFFFF, 1'b0);
    send(3'd2, 16'd1,     16'd0,    1'b0);
    send(3'd0, 16'h0100,  16'h0100, 1'b0);
    send(3'd1, 16'h0100,  16'd0,    1'b0);
    send(3'd0, 16'd10,    16'd10,   1'b0);
    drain();

    // 5: cmd_valid held through busy with a changing operand
    begin
      exp_t e;
      @(negedge clk);
      wait_ready();
      cmd_valid = 1'b1;
      cmd_op = 3'd2;
      cmd_operand = 16'd4;
      e.ac = 16'd14; e.err = 1'b0;
      exp_q.push_back(e);
      @(posedge clk);
      for (int k = 0; k < 10; k++) begin
        @(negedge clk);
        if (cmd_ready) break;
        cmd_operand = 16'(1000 + k * 1000);
      end
      chk("bp_ready", 32'(cmd_ready), 32'd1);
      cmd_operand = 16'd10;
      e.ac = 16'd24;
      exp_q.push_back(e);
      @(posedge clk);
      #1 cmd_valid = 1'b0;
    end
    drain();
    chk("bp_ac", 32'(ac_out), 32'd24);

    // 6: reset while a command is in EXEC
    @(negedge clk);
    wait_ready();
    cmd_valid = 1'b1;
    cmd_op = 3'd0;
    cmd_operand = 16'd100;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rstx_ac", 32'(ac_out), 32'd0);
    chk("rstx_ready", 32'(cmd_ready), 32'd1);
    chk("rstx_bus", 32'(alu_in_bus), 32'd0);
    repeat (4) begin
      @(negedge clk);
      chk("rstx_no_done", 32'(done), 32'd0);
    end

    // reset and cmd_valid together: command must not be taken
    rst = 1'b1;
    cmd_valid = 1'b1;
    cmd_op = 3'd0;
    cmd_operand = 16'd55;
    @(posedge clk);
    #1 begin rst = 1'b0; cmd_valid = 1'b0; end
    @(negedge clk);
    chk("rstv_ready", 32'(cmd_ready), 32'd1);
    chk("rstv_bus", 32'(alu_in_bus), 32'd0);
    repeat (3) @(negedge clk);
    chk("rstv_ac", 32'(ac_out), 32'd0);

    send(3'd0, 16'd3, 16'd3, 1'b0);
    drain();
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
